ds_dac_multi: RTL and testbench
===============================

// Module: ds_dac_multi
// PURPOSE
//  N-channel 1-bit delta-sigma PCM-to-PDM DAC, successor to the single-channel first-order DAC.
//  Adds runtime-selectable 1st/2nd-order noise shaping, a modulator-rate prescaler, and a
//  valid/ready sample port with a double-buffered sample register (shadow -> active).
//  Sits between the synth voice mixer and the board PDM/RC-filter audio pins.
// PARAMETERS
//  W    16      PCM sample width, signed two's complement
//  N    2       channel count
//  OSR  64      modulator ticks per audio frame (>=2)
//  DIV  1       clk cycles per modulator tick (>=1; 1 = every clk)
//  IW   W+4     integrator width, signed
// PORTS
//  clk          in   1    system clock
//  reset_n      in   1    asynchronous reset, active-low
//  enable       in   1    modulator run; low = synchronous clear (see below)
//  order2       in   1    0 = first order, 1 = second order; sampled at frame boundary only
//  pcm_in       in   N*W  channel c in bits [c*W +: W]
//  pcm_valid    in   1    pcm_in holds a frame
//  pcm_ready    out  1    shadow register empty; frame accepted when valid&ready
//  underrun     out  1    sticky: frame boundary reached with shadow empty
//  underrun_clr in   1    clears underrun (set wins if same cycle)
//  pdm_out      out  N    1-bit PDM stream per channel, registered
// BEHAVIOUR
//  Reset: all integrators, counters, active/shadow samples = 0; shadow empty; order latch = 0;
//   pdm_out = 0; pcm_ready = 1; underrun = 0.
//  Tick: prescaler counts 0..DIV-1; tick = (count == DIV-1). Frame counter counts ticks
//   0..OSR-1; boundary = tick & (frame count == OSR-1).
//  Handshake: pcm_ready = !shadow_full (from register, no comb path from pcm_valid).
//   valid&ready loads shadow, sets full next cycle.
//  Boundary: shadow full -> active <= shadow, shadow empty, order latch <= order2.
//   Shadow empty and valid&ready same cycle -> bypass: pcm_in straight to active, no underrun.
//   Otherwise active holds and underrun set.
//  Modulator, per channel, on tick only, FS = 2**(W-1), fb = pdm_out[c] ? +FS : -FS:
//   Order 1: i1' = sat(i1 + x - fb); pdm' = (i1' >= 0).
//   Order 2: x clamped to [-7*FS/8, +7*FS/8];
//    i1' = sat(i1 + x - fb); i2' = sat(i2 + i1' - fb); pdm' = (i2' >= 0).
//   sat() clamps to [-2**(IW-2), 2**(IW-2)-1], with all adds done in IW bits.
//   Order latch 2 -> 1 clears i2 at that boundary.
//   Latency: a frame in active affects pdm_out on the first tick after the boundary.
//  enable low: prescaler, frame counter, integrators, active samples cleared; pdm_out = 0.
//   Shadow and handshake still operate; no underrun is flagged.
//   Restart at enable rise begins at frame count 0.
//  reset_n assert mid-frame: immediate clear to reset values, pending shadow frame discarded.
// STRUCTURE
//  ds_dac_pkg: typedef ds_order_e {DS_ORD1, DS_ORD2}; function fs(W); clamp constant 7/8.
//  Sub-module ds_mod_core: one channel (x, tick, clear, order, clr_i2 -> pdm). Instantiated N
//   times by generate. Top holds prescaler, frame counter, shadow/active regs, handshake, flag.
// TESTING  (W=16, N=2, OSR=64)
//  Reset: release reset_n, no stimulus -> pdm_out=00, pcm_ready=1, underrun=0, 10 cycles.
//  Order 1, DIV=1, frame {0, +16384} -> over 256 ticks: ch0 has 128+/-1 ones, ch1 192+/-1 ones.
//  Order 2, frame {+32767, -32768} -> clamped; ch0 density 0.9375+/-2/256,
//   ch1 0.0625+/-2/256; integrators never at sat bound.
//  Backpressure: two frames back-to-back -> second waits with pcm_ready=0 until the boundary
//   after the first; pcm_ready rises the cycle after that boundary.
//  Underrun: skip one frame -> underrun=1 at that boundary, active held (density unchanged);
//   underrun_clr -> 0; clr and new set same cycle -> stays 1.
//  DIV=4, then reset_n low mid-frame -> pdm changes only every 4th clk;
//   reset clears within same edge; post-reset first tick at clk 4.

Source files
------------

// File: rtl/ds_dac_pkg.sv
// Shared types and constants for the multi-channel delta-sigma PDM DAC.
package ds_dac_pkg;

  // Noise-shaping order selected at frame boundaries.
  typedef enum logic {
    DS_ORD1 = 1'b0,
    DS_ORD2 = 1'b1
  } ds_order_e;

  // Second-order input is limited to 7/8 of full scale to keep the loop stable.
  localparam int CLAMP_NUM = 7;
  localparam int CLAMP_DEN = 8;

  // Full-scale magnitude of a signed w-bit sample: 2**(w-1).
  function automatic int fs(input int w);
    return 32'sd1 <<< (w - 1);
  endfunction

endpackage

// File: rtl/ds_mod_core.sv
// One channel of the delta-sigma modulator: 1st/2nd-order loop with saturating integrators.
module ds_mod_core
  import ds_dac_pkg::*;
#(
  parameter int W  = 16,
  parameter int IW = W + 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [W-1:0] x,
  input  logic                tick,
  input  logic                clear,
  input  ds_order_e           order,
  input  logic                clr_i2,
  output logic                pdm
);

  localparam logic signed [IW-1:0] FS_P   = IW'(fs(W));
  localparam logic signed [IW-1:0] FS_N   = IW'(-fs(W));
  localparam logic signed [IW-1:0] CLP_HI = IW'(fs(W) * CLAMP_NUM / CLAMP_DEN);
  localparam logic signed [IW-1:0] CLP_LO = IW'(-(fs(W) * CLAMP_NUM / CLAMP_DEN));
  localparam logic signed [IW-1:0] SAT_HI = {2'b00, {(IW-2){1'b1}}};
  localparam logic signed [IW-1:0] SAT_LO = {2'b11, {(IW-2){1'b0}}};

  logic signed [IW-1:0] x_ext, x_eff, fb, i1_r, i2_r, i1_nxt, i2_nxt;
  logic                 pdm_nxt;

  // Clamp to the integrator range; all sums are formed in IW bits.
  function automatic logic signed [IW-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI;
    end else if (v < SAT_LO) begin
      return SAT_LO;
    end else begin
      return v;
    end
  endfunction

  assign x_ext = {{(IW-W){x[W-1]}}, x};
  assign fb    = pdm ? FS_P : FS_N;

  // Input conditioning: second order sees the input limited to +/-7/8 full scale.
  always_comb begin
    x_eff = x_ext;
    if (order == DS_ORD2) begin
      if (x_ext > CLP_HI) begin
        x_eff = CLP_HI;
      end else if (x_ext < CLP_LO) begin
        x_eff = CLP_LO;
      end else begin
        x_eff = x_ext;
      end
    end else begin
      x_eff = x_ext;
    end
  end

  // Loop update candidates; the quantiser reads the last integrator of the active order.
  always_comb begin
    i1_nxt  = sat(i1_r + x_eff - fb);
    i2_nxt  = sat(i2_r + i1_nxt - fb);
    pdm_nxt = 1'b0;
    if (order == DS_ORD2) begin
      pdm_nxt = ~i2_nxt[IW-1];
    end else begin
      pdm_nxt = ~i1_nxt[IW-1];
    end
  end

  // Integrator and output state; i2 only advances in second order and is dropped on 2->1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1_r <= '0;
      i2_r <= '0;
      pdm  <= 1'b0;
    end else if (clear) begin
      i1_r <= '0;
      i2_r <= '0;
      pdm  <= 1'b0;
    end else begin
      if (tick) begin
        i1_r <= i1_nxt;
        pdm  <= pdm_nxt;
        if (order == DS_ORD2) begin
          i2_r <= i2_nxt;
        end
      end
      if (clr_i2) begin
        i2_r <= '0;
      end
    end
  end

endmodule

// File: rtl/ds_dac_multi.sv
// N-channel PCM-to-PDM delta-sigma DAC with prescaler, framing and a double-buffered sample port.
module ds_dac_multi
  import ds_dac_pkg::*;
#(
  parameter int W   = 16,
  parameter int N   = 2,
  parameter int OSR = 64,
  parameter int DIV = 1,
  parameter int IW  = W + 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           order2,
  input  logic [N*W-1:0] pcm_in,
  input  logic           pcm_valid,
  output logic           pcm_ready,
  output logic           underrun,
  input  logic           underrun_clr,
  output logic [N-1:0]   pdm_out
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = $clog2(OSR);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(OSR - 1);

  logic [PW-1:0]  pcnt_r;
  logic [FW-1:0]  fcnt_r;
  logic [N*W-1:0] shadow_r, active_r;
  logic           shadow_empty_r, underrun_r;
  ds_order_e      order_r, order_in_s;
  logic           tick_s, boundary_s, accept_s, clr_i2_s;

  assign pcm_ready = shadow_empty_r;
  assign underrun  = underrun_r;

  // Tick/boundary strobes and handshake decode.
  always_comb begin
    tick_s     = enable & (pcnt_r == P_LAST);
    boundary_s = tick_s & (fcnt_r == F_LAST);
    accept_s   = pcm_valid & shadow_empty_r;
    order_in_s = order2 ? DS_ORD2 : DS_ORD1;
    clr_i2_s   = boundary_s & (order_r == DS_ORD2) & (order_in_s == DS_ORD1);
  end

  // Modulator-rate prescaler; held at zero while disabled so restarts are aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_r <= '0;
    end else if (!enable || tick_s) begin
      pcnt_r <= '0;
    end else begin
      pcnt_r <= pcnt_r + PW'(1);
    end
  end

  // Frame position in modulator ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_r <= '0;
    end else if (!enable) begin
      fcnt_r <= '0;
    end else if (boundary_s) begin
      fcnt_r <= '0;
    end else if (tick_s) begin
      fcnt_r <= fcnt_r + FW'(1);
    end
  end

  // Shadow register: filled by the handshake, emptied when handed to active at a boundary.
  // A frame arriving exactly at a boundary with the shadow empty bypasses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r       <= '0;
      shadow_empty_r <= 1'b1;
    end else if (accept_s && !boundary_s) begin
      shadow_r       <= pcm_in;
      shadow_empty_r <= 1'b0;
    end else if (boundary_s && !shadow_empty_r) begin
      shadow_empty_r <= 1'b1;
    end
  end

  // Active samples and order latch; both only change at a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_r <= '0;
      order_r  <= DS_ORD1;
    end else if (!enable) begin
      active_r <= '0;
    end else if (boundary_s) begin
      order_r <= order_in_s;
      if (!shadow_empty_r) begin
        active_r <= shadow_r;
      end else if (accept_s) begin
        active_r <= pcm_in;
      end
    end
  end

  // Sticky underrun flag; a new underrun outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_r <= 1'b0;
    end else if (boundary_s && shadow_empty_r && !accept_s) begin
      underrun_r <= 1'b1;
    end else if (underrun_clr) begin
      underrun_r <= 1'b0;
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_ch
    ds_mod_core #(.W(W), .IW(IW)) u_core (
      .clk    (clk),
      .reset_n(reset_n),
      .x      (active_r[c*W +: W]),
      .tick   (tick_s),
      .clear  (~enable),
      .order  (order_r),
      .clr_i2 (clr_i2_s),
      .pdm    (pdm_out[c])
    );
  end

endmodule

// File: tb/tb_ds_dac_multi.sv
// Directed bench for ds_dac_multi: reset, handshake, underrun, densities and prescaled reset.
module tb_ds_dac_multi;
  localparam int W = 16, N = 2, OSR = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, enable, order2, pcm_valid, underrun_clr, pcm_ready, underrun;
  logic [N*W-1:0] pcm_in;
  logic [N-1:0]   pdm_out;
  logic reset_n4, enable4, order24, pcm_valid4, underrun_clr4, pcm_ready4, underrun4;
  logic [N*W-1:0] pcm_in4;
  logic [N-1:0]   pdm_out4;

  ds_dac_multi #(.W(W), .N(N), .OSR(OSR), .DIV(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .order2(order2),
    .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .underrun(underrun), .underrun_clr(underrun_clr), .pdm_out(pdm_out));

  ds_dac_multi #(.W(W), .N(N), .OSR(OSR), .DIV(4)) u_div4 (
    .clk(clk), .reset_n(reset_n4), .enable(enable4), .order2(order24),
    .pcm_in(pcm_in4), .pcm_valid(pcm_valid4), .pcm_ready(pcm_ready4),
    .underrun(underrun4), .underrun_clr(underrun_clr4), .pdm_out(pdm_out4));

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  typedef struct {
    logic ord;
    int   x0;
    int   x1;
    int   exp0;
    int   exp1;
    int   tol;
  } dens_vec_t;

  dens_vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_rng(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic run_to(input int e);
    while (edge_cnt < e) step();
  endtask

  task automatic measure(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      c0 += int'(pdm_out[0]);
      c1 += int'(pdm_out[1]);
    end
  endtask

  function automatic logic [N*W-1:0] frame(input int x0, input int x1);
    return {W'(x1), W'(x0)};
  endfunction

  initial begin
    int c0, c1, bad;
    logic [N-1:0] prev;

    vecs[0] = '{1'b0,      0,  16384, 128, 192, 1};
    vecs[1] = '{1'b0, -16384,   8192,  64, 160, 1};
    vecs[2] = '{1'b1,  32767, -32768, 240,  16, 2};
    vecs[3] = '{1'b1,      0,  16384, 128, 192, 2};

    reset_n = 1'b0; enable = 1'b0; order2 = 1'b0; pcm_valid = 1'b0;
    underrun_clr = 1'b0; pcm_in = '0;
    reset_n4 = 1'b0; enable4 = 1'b1; order24 = 1'b0; pcm_valid4 = 1'b0;
    underrun_clr4 = 1'b0; pcm_in4 = '0;

    // Reset state, then 10 idle cycles after release.
    repeat (3) step();
    check("rst_ready", pcm_ready, 1);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_pdm", pdm_out, 0);
      check("idle_ready", pcm_ready, 1);
      check("idle_underrun", underrun, 0);
    end

    // DIV=4: first tick at clk 4, output moves only on every 4th clk.
    reset_n4 = 1'b1;
    prev = pdm_out4;
    bad = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if ((k % 4) != 0 && pdm_out4 != prev) bad++;
      prev = pdm_out4;
      if (k == 3)  check("div4_pre_tick", pdm_out4, 0);
      if (k == 4)  check("div4_tick1", pdm_out4, 3);
      if (k == 12) check("div4_tick3", pdm_out4, 0);
      if (k == 16) check("div4_tick4", pdm_out4, 3);
      if (k == 20) check("div4_tick5", pdm_out4, 0);
      if (k == 25) check("div4_tick6", pdm_out4, 3);
      if (k == 5) begin
        pcm_in4 = frame(-32768, -32768);
        pcm_valid4 = 1'b1;
      end
      if (k == 6) begin
        pcm_valid4 = 1'b0;
        check("div4_shadow_full", pcm_ready4, 0);
      end
    end
    check("div4_only_every_4th", bad, 0);
    // Asynchronous reset mid-frame clears immediately and drops the pending frame.
    #2 reset_n4 = 1'b0;
    #1;
    check("div4_async_pdm", pdm_out4, 0);
    check("div4_async_ready", pcm_ready4, 1);
    check("div4_async_underrun", underrun4, 0);
    step();
    reset_n4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) check("div4_post_rst_pre", pdm_out4, 0);
      if (k == 4) check("div4_post_rst_tick1", pdm_out4, 3);
    end

    // Backpressure: frame A accepted, B waits until the boundary after A.
    enable = 1'b1;
    pcm_in = frame(-16384, 8192);
    pcm_valid = 1'b1;
    edge_cnt = 0;
    step();
    pcm_in = frame(0, 16384);
    check("bp_ready_low", pcm_ready, 0);
    run_to(63);
    check("bp_ready_before_bnd", pcm_ready, 0);
    run_to(64);
    check("bp_ready_after_bnd", pcm_ready, 1);
    check("bp_no_underrun", underrun, 0);
    run_to(65);
    check("bp_b_accepted", pcm_ready, 0);
    pcm_valid = 1'b0;

    // Underrun on the skipped frame; active held at B.
    run_to(191);
    check("ur_before", underrun, 0);
    run_to(192);
    check("ur_set", underrun, 1);
    measure(c0, c1);
    check_rng("ur_hold_dens_ch0", c0, 128, 1);
    check_rng("ur_hold_dens_ch1", c1, 192, 1);
    run_to(449);
    underrun_clr = 1'b1;
    run_to(450);
    check("ur_clear", underrun, 0);
    underrun_clr = 1'b0;
    run_to(511);
    underrun_clr = 1'b1;
    run_to(512);
    check("ur_set_wins", underrun, 1);
    underrun_clr = 1'b0;

    // Density table with a continuously valid source.
    pcm_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      order2 = vecs[i].ord;
      pcm_in = frame(vecs[i].x0, vecs[i].x1);
      repeat (200) step();
      measure(c0, c1);
      check_rng($sformatf("dens%0d_ch0", i), c0, vecs[i].exp0, vecs[i].tol);
      check_rng($sformatf("dens%0d_ch1", i), c1, vecs[i].exp1, vecs[i].tol);
    end

    // Disable forces the outputs low.
    enable = 1'b0;
    step();
    check("disable_pdm", pdm_out, 0);
    step();
    check("disable_pdm_hold", pdm_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
